// File: rtl/packet_serializer_pkg.sv
// Shared definitions for the stream packet serializer and the matching parser.
// Contents:
//   HDR_BYTES, MAX_BYTES, NUM_STREAMS, WORD_W - packet geometry
//   state_t                                   - serializer FSM state encoding
//   words_for_len()                           - payload bytes -> 32-bit data words
package packet_serializer_pkg;

  localparam int HDR_BYTES   = 8;
  localparam int MAX_BYTES   = 37;
  localparam int NUM_STREAMS = 32;
  localparam int WORD_W      = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR0 = 2'd1,
    HDR1 = 2'd2,
    DATA = 2'd3
  } state_t;

  // ceil(len/4); computed in 7 bits so len+3 cannot overflow.
  function automatic logic [3:0] words_for_len(input logic [5:0] len);
    return 4'(({1'b0, len} + 7'd3) >> 2);
  endfunction

endpackage

// File: rtl/packet_serializer_seq_table.sv
// seq_table: per-stream sequence counter storage.
// Ports:
//   clk, reset      - rising-edge clock, synchronous active-high clear
//   rdAddr, rdData  - combinational read port
//   wrEn, wrAddr,
//   wrData          - single write port, written on the rising edge when wrEn
module seq_table
  import packet_serializer_pkg::*;
#(
  parameter int NUM_STREAMS = packet_serializer_pkg::NUM_STREAMS,
  parameter int WORD_W      = 32,
  localparam int IDX_W      = $clog2(NUM_STREAMS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rdAddr,
  output logic [WORD_W-1:0] rdData,
  input  logic              wrEn,
  input  logic [IDX_W-1:0]  wrAddr,
  input  logic [WORD_W-1:0] wrData
);

  logic [WORD_W-1:0] mem [NUM_STREAMS];

  assign rdData = mem[rdAddr];

  // NOTE: non-blocking assignments in clocked blocks so every register samples
  // its inputs from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: this storage is deliberately cleared on reset (a flop array, not
      // a RAM macro) because the far-end parser expects every stream to restart
      // at seq 1 after a reset.
      for (int i = 0; i < NUM_STREAMS; i++) begin
        mem[i] <= '0;
      end
    end else if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

endmodule

// File: rtl/packet_serializer.sv
// packet_serializer: turns one payload (1..MAX_BYTES bytes) plus a stream ID
// into a packet of 32-bit words: {len+8, streamId}, seq, then payload words.
// Ports:
//   clk, reset                  - rising-edge clock, synchronous active-high reset
//   payloadIn, payloadLen,
//   streamId, payloadIn_val,
//   payloadIn_ready             - payload request (byte 0 = payloadIn[0:7])
//   lenError                    - one-cycle pulse when an illegal length is dropped
//   dataOut, dataOut_val,
//   dataOut_ready, dataOut_last - output word stream with valid/ready/last
module packet_serializer
  import packet_serializer_pkg::*;
#(
  parameter int MAX_BYTES   = packet_serializer_pkg::MAX_BYTES,
  parameter int NUM_STREAMS = packet_serializer_pkg::NUM_STREAMS,
  parameter int WORD_W      = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [0:MAX_BYTES*8-1] payloadIn,
  input  logic [5:0]             payloadLen,
  input  logic [15:0]            streamId,
  input  logic                   payloadIn_val,
  output logic                   payloadIn_ready,
  output logic                   lenError,
  output logic [WORD_W-1:0]      dataOut,
  output logic                   dataOut_val,
  input  logic                   dataOut_ready,
  output logic                   dataOut_last
);

  localparam int IDX_W = $clog2(NUM_STREAMS);

  state_t                 state;
  state_t                 nextState;
  logic [0:MAX_BYTES*8-1] payloadReg;
  logic [5:0]             lenReg;
  logic [15:0]            streamReg;
  logic [31:0]            seqReg;
  logic [3:0]             wordIdx;
  logic [3:0]             lastIdx;
  logic [31:0]            seqRd;
  logic [31:0]            dataWord;
  logic                   lenLegal;
  logic                   accept;
  logic                   handshake;
  logic                   isLastWord;
  logic                   commit;

  assign lenLegal   = (payloadLen != 6'd0) && (payloadLen <= 6'(MAX_BYTES));
  assign accept     = (state == IDLE) && payloadIn_val && lenLegal;
  assign handshake  = dataOut_val && dataOut_ready;
  assign lastIdx    = words_for_len(lenReg) - 4'd1;
  assign isLastWord = (state == DATA) && (wordIdx == lastIdx);
  // The counter is only advanced once the whole packet has left, so an
  // abandoned packet (reset) never consumes a sequence number.
  assign commit     = handshake && isLastWord;

  seq_table #(
    .NUM_STREAMS (NUM_STREAMS),
    .WORD_W      (32)
  ) seqTable (
    .clk    (clk),
    .reset  (reset),
    .rdAddr (streamId[IDX_W-1:0]),
    .rdData (seqRd),
    .wrEn   (commit),
    .wrAddr (streamReg[IDX_W-1:0]),
    .wrData (seqReg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    // NOTE: default assignment first so every path drives nextState and no
    // latch is inferred.
    nextState = state;
    unique case (state)
      IDLE: if (accept)                 nextState = HDR0;
      HDR0: if (handshake)              nextState = HDR1;
      HDR1: if (handshake)              nextState = DATA;
      DATA: if (handshake && isLastWord) nextState = IDLE;
      default:                          nextState = IDLE;
    endcase
  end

  // Control registers that must come out of reset in a known state.
  always_ff @(posedge clk) begin
    if (reset) begin
      lenError <= 1'b0;
      wordIdx  <= 4'd0;
    end else begin
      lenError <= (state == IDLE) && payloadIn_val && !lenLegal;
      if (accept) begin
        wordIdx <= 4'd0;
      end else if (handshake && (state == DATA) && !isLastWord) begin
        wordIdx <= wordIdx + 4'd1;
      end
    end
  end

  // Packet capture; contents are only observed while state != IDLE, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      payloadReg <= payloadIn;
      lenReg     <= payloadLen;
      streamReg  <= streamId;
      seqReg     <= seqRd + 32'd1;
    end
  end

  // Current data word: bytes 4*wordIdx..4*wordIdx+3, MSB first, zero past len.
  always_comb begin
    dataWord = '0;
    for (int j = 0; j < MAX_BYTES; j++) begin
      if (((j / 4) == int'(wordIdx)) && (j < int'(lenReg))) begin
        dataWord[31-8*(j%4) -: 8] = payloadReg[8*j +: 8];
      end
    end
  end

  always_comb begin
    dataOut = '0;
    unique case (state)
      HDR0:    dataOut = {16'(lenReg) + 16'(HDR_BYTES), streamReg};
      HDR1:    dataOut = seqReg;
      DATA:    dataOut = dataWord;
      default: dataOut = '0;
    endcase
  end

  assign payloadIn_ready = (state == IDLE);
  assign dataOut_val     = (state != IDLE);
  assign dataOut_last    = isLastWord;

endmodule

// File: tb/tb_packet_serializer.sv
module tb_packet_serializer;

  localparam int MAXB = 37;

  logic              clk = 1'b0;
  logic              reset;
  logic [0:MAXB*8-1] payloadIn;
  logic [5:0]        payloadLen;
  logic [15:0]       streamId;
  logic              payloadIn_val;
  logic              payloadIn_ready;
  logic              lenError;
  logic [31:0]       dataOut;
  logic              dataOut_val;
  logic              dataOut_ready;
  logic              dataOut_last;

  int checks   = 0;
  int failures = 0;

  packet_serializer dut (
    .clk             (clk),
    .reset           (reset),
    .payloadIn       (payloadIn),
    .payloadLen      (payloadLen),
    .streamId        (streamId),
    .payloadIn_val   (payloadIn_val),
    .payloadIn_ready (payloadIn_ready),
    .lenError        (lenError),
    .dataOut         (dataOut),
    .dataOut_val     (dataOut_val),
    .dataOut_ready   (dataOut_ready),
    .dataOut_last    (dataOut_last)
  );

  always #5 clk = ~clk;

  // Payload byte i of a packet is seed*(i+1); bytes past len are filled with 0xEE
  // on the input so zero-padding of the final word is exercised.
  typedef struct {
    logic [15:0] sid;
    logic [5:0]  len;
    logic [7:0]  seed;
    bit          stall;
    logic [31:0] hdr0;
    logic [31:0] seq;
    int          nWords;
    logic [31:0] lastWord;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input vec_t v, input int k);
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < 4; b++) begin
      if (4*k + b < int'(v.len)) w[31-8*b -: 8] = 8'(int'(v.seed) * (4*k + b + 1));
    end
    return w;
  endfunction

  // Called at a negedge; leaves the request driven for the next rising edge.
  task automatic send_pkt(input vec_t v);
    logic [0:MAXB*8-1] p;
    int w;
    w = 0;
    while (!payloadIn_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("accept_ready", 32'(payloadIn_ready), 32'd1);
    for (int i = 0; i < MAXB; i++) begin
      p[i*8 +: 8] = (i < int'(v.len)) ? 8'(int'(v.seed) * (i + 1)) : 8'hEE;
    end
    payloadIn     = p;
    payloadLen    = v.len;
    streamId      = v.sid;
    payloadIn_val = 1'b1;
  endtask

  task automatic rx_pkt(input vec_t v);
    int          k;
    int          cyc;
    int          dataCyc;
    bit          stalled;
    bit          rdy;
    logic [31:0] hold;
    logic        holdLast;
    logic [31:0] exp;
    k = 0; cyc = 0; dataCyc = 0; stalled = 0; hold = '0; holdLast = 1'b0;
    while (k < v.nWords + 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      payloadIn_val = 1'b0;
      if (stalled) begin
        check("stall_val",  32'(dataOut_val),  32'd1);
        check("stall_data", dataOut,           hold);
        check("stall_last", 32'(dataOut_last), 32'(holdLast));
      end
      rdy = 1'b1;
      if (v.stall && k >= 2) begin
        rdy = (dataCyc % 4 == 0) || (dataCyc % 4 == 3);
        dataCyc++;
      end
      dataOut_ready = rdy;
      if (dataOut_val && rdy) begin
        if (k == 0)      exp = v.hdr0;
        else if (k == 1) exp = v.seq;
        else             exp = model_word(v, k - 2);
        check($sformatf("word%0d_s%0h", k, v.sid), dataOut, exp);
        check($sformatf("last%0d_s%0h", k, v.sid), 32'(dataOut_last),
              32'(k == v.nWords + 1));
        if (k == v.nWords + 1) check("last_word_hand", dataOut, v.lastWord);
        k++;
        stalled = 1'b0;
      end else begin
        stalled  = dataOut_val;
        hold     = dataOut;
        holdLast = dataOut_last;
      end
    end
    if (k < v.nWords + 2) check("rx_timeout_words", 32'(k), 32'(v.nWords + 2));
    if (!v.stall) check("pkt_cycles", 32'(cyc), 32'(v.nWords + 2));
    dataOut_ready = 1'b1;
    @(negedge clk);
    check("ready_after_last", 32'(payloadIn_ready), 32'd1);
    check("idle_val",         32'(dataOut_val),     32'd0);
  endtask

  task automatic run_pkt(input vec_t v);
    send_pkt(v);
    rx_pkt(v);
  endtask

  task automatic illegal_len(input logic [5:0] len);
    payloadIn     = '0;
    payloadLen    = len;
    streamId      = 16'd20;
    payloadIn_val = 1'b1;
    @(negedge clk);
    payloadIn_val = 1'b0;
    check("lenerr_pulse", 32'(lenError),        32'd1);
    check("lenerr_noval", 32'(dataOut_val),     32'd0);
    check("lenerr_ready", 32'(payloadIn_ready), 32'd1);
    @(negedge clk);
    check("lenerr_once",  32'(lenError),        32'd0);
    check("lenerr_noval2", 32'(dataOut_val),    32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //            sid       len    seed   stall hdr0          seq           N   lastWord
    vecs[0] = '{16'h0003, 6'd5,  8'h11, 1'b0, 32'h000D0003, 32'h00000001, 2,  32'h55000000};
    vecs[1] = '{16'h0007, 6'd37, 8'h01, 1'b0, 32'h002D0007, 32'h00000001, 10, 32'h25000000};
    vecs[2] = '{16'h0007, 6'd37, 8'h02, 1'b0, 32'h002D0007, 32'h00000002, 10, 32'h4A000000};
    vecs[3] = '{16'h0005, 6'd4,  8'h10, 1'b0, 32'h000C0005, 32'h00000001, 1,  32'h10203040};
    vecs[4] = '{16'h0025, 6'd1,  8'hAB, 1'b0, 32'h00090025, 32'h00000002, 1,  32'hAB000000};
    vecs[5] = '{16'h0005, 6'd6,  8'h03, 1'b0, 32'h000E0005, 32'h00000003, 2,  32'h0F120000};
    vecs[6] = '{16'hFFE3, 6'd2,  8'h07, 1'b0, 32'h000AFFE3, 32'h00000002, 1,  32'h070E0000};
    vecs[7] = '{16'h0009, 6'd3,  8'h20, 1'b0, 32'h000B0009, 32'h00000001, 1,  32'h20406000};
    vecs[8] = '{16'h000C, 6'd9,  8'h05, 1'b1, 32'h0011000C, 32'h00000001, 3,  32'h2D000000};
    vecs[9] = '{16'h0003, 6'd8,  8'h01, 1'b1, 32'h00100003, 32'h00000003, 2,  32'h05060708};

    reset         = 1'b1;
    payloadIn     = '0;
    payloadLen    = '0;
    streamId      = '0;
    payloadIn_val = 1'b0;
    dataOut_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready",    32'(payloadIn_ready), 32'd1);
    check("rst_val",      32'(dataOut_val),     32'd0);
    check("rst_last",     32'(dataOut_last),    32'd0);
    check("rst_data",     dataOut,              32'd0);
    check("rst_lenerr",   32'(lenError),        32'd0);
    reset         = 1'b0;
    dataOut_ready = 1'b1;
    @(negedge clk);
    check("idle_ready_ignored", 32'(dataOut_val), 32'd0);

    // Basic, max-size back-to-back, aliasing 5/37, full-width stream ID, stalls.
    for (int i = 0; i < 10; i++) run_pkt(vecs[i]);

    // Illegal lengths are dropped without touching stream 20's counter.
    illegal_len(6'd0);
    illegal_len(6'd38);
    v = '{16'h0014, 6'd2, 8'h40, 1'b0, 32'h000A0014, 32'h00000001, 1, 32'h40800000};
    run_pkt(v);

    // Sequence wrap on counter 0.
    dut.seqTable.mem[0] = 32'hFFFF_FFFF;
    v = '{16'h0000, 6'd4, 8'h01, 1'b0, 32'h000C0000, 32'h00000000, 1, 32'h01020304};
    run_pkt(v);
    v = '{16'h0000, 6'd4, 8'h02, 1'b0, 32'h000C0000, 32'h00000001, 1, 32'h02040608};
    run_pkt(v);

    // Reset during HDR1: stream 3 counter is 3, so this packet would carry seq 4.
    send_pkt(vecs[0]);
    @(negedge clk);
    payloadIn_val = 1'b0;
    check("abort_hdr0", dataOut, 32'h000D0003);
    dataOut_ready = 1'b1;
    @(negedge clk);
    check("abort_hdr1", dataOut, 32'h00000004);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_val",   32'(dataOut_val),     32'd0);
    check("abort_last",  32'(dataOut_last),    32'd0);
    check("abort_ready", 32'(payloadIn_ready), 32'd1);
    run_pkt(vecs[0]);
    v = '{16'h0007, 6'd4, 8'h01, 1'b0, 32'h000C0007, 32'h00000001, 1, 32'h01020304};
    run_pkt(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/packet_serializer.md
Name: packet_serializer

Overview:
- Transmit-side counterpart of the stream packet parser.
- Accepts one payload of up to 37 bytes with a stream ID, and prepends a two-word header: {length, stream} followed by a 32-bit sequence number.
- Emits the packet as 32-bit words on a valid/ready/last interface.
- Keeps a per-stream sequence counter so the far-end parser sees seq = previous + 1 on every stream.

Parameters:
- MAX_BYTES, 37, maximum payload bytes per packet; payload bus width is MAX_BYTES*8.
- NUM_STREAMS, 32, number of sequence counters; indexed by streamId[log2(NUM_STREAMS)-1:0].
- WORD_W, 32, output word width; fixed at 32.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous reset, active-high.
- payloadIn  in  [0:MAX_BYTES*8-1]  payload; byte 0 is payloadIn[0:7].
- payloadLen  in  6  payload byte count; legal range 1..MAX_BYTES.
- streamId  in  16  stream identifier, copied into the header.
- payloadIn_val  in  1  payload request valid.
- payloadIn_ready  out  1  block can accept a payload.
- lenError  out  1  one-cycle pulse when an illegal payloadLen is dropped.
- dataOut  out  32  output word.
- dataOut_val  out  1  dataOut is valid.
- dataOut_ready  in  1  downstream accepts the word.
- dataOut_last  out  1  final word of the packet; qualified by dataOut_val.

Behaviour:
- Reset values:
  - payloadIn_ready=1, dataOut_val=0, dataOut_last=0, dataOut=0, lenError=0.
  - All sequence counters = 0; state = IDLE.
- States and transitions:
  - IDLE -> HDR0: on payloadIn_val with a legal length.
  - HDR0 -> HDR1 -> DATA: each transition on a dataOut handshake (dataOut_val && dataOut_ready).
  - DATA -> IDLE: on handshake of the last word.
- payloadIn_ready = (state == IDLE).
- Accept at edge k:
  - Payload, len, stream and seq = counter[stream]+1 are registered.
  - From the cycle after edge k, dataOut_val=1 and dataOut presents header word 0.
- Header word 0 = {len16, streamId}, where len16 = payloadLen + 8 (zero-extended 16-bit).
- Header word 1 = seq (32-bit; wraps 0xFFFFFFFF -> 0x00000000).
- Data words:
  - Word count N = ceil(payloadLen/4).
  - Word i = payload bytes 4i..4i+3, with byte 4i in [31:24].
  - In the final word, bytes beyond payloadLen are driven 0.
- dataOut_last = 1 only on data word N-1.
- Handshake rules:
  - dataOut and dataOut_last are held stable while dataOut_val && !dataOut_ready.
  - The word advances only on a handshake; throughput is one word per cycle while ready=1.
- Sequence commit:
  - counter[stream] <= seq on the handshake of the last word, not at accept.
  - The IDLE cycle after that handshake makes a back-to-back same-stream packet read the updated value.
  - Per packet: 2+N output cycles plus 1 IDLE cycle minimum.
- Stream index uses the low bits of streamId only. Streams 5 and 37 share counter 5.
- Illegal length (payloadLen==0 or >MAX_BYTES) while in IDLE with payloadIn_val:
  - The payload is consumed (ready was 1).
  - Nothing is emitted and no counter changes.
  - lenError=1 for the following cycle; state stays IDLE.
- Reset mid-packet: next cycle dataOut_val=0, counters cleared, partial packet abandoned with no last word.
- dataOut_ready high while dataOut_val=0 has no effect.

Decomposition:
- Shared package (for the serializer and the existing parser):
  - HDR_BYTES=8, MAX_BYTES=37, NUM_STREAMS=32.
  - Localparam state encoding IDLE/HDR0/HDR1/DATA.
  - Function words_for_len(len) returning ceil(len/4).
- One natural sub-module: seq_table, a NUM_STREAMS x 32 register file.
  - Combinational read port.
  - One write port with enable.
  - Synchronous clear on reset.
- The FSM and word mux remain in packet_serializer.

Test Plan:
- Basic packet, dataOut_ready=1:
  - Stimulus: stream 3, len 5, bytes 0x11..0x55.
  - Required response: words 0x000D0003, 0x00000001, 0x11223344, 0x55000000 (last=1) on consecutive cycles; ready returns 1 the cycle after last.
- Max size, back-to-back same stream:
  - Stimulus: stream 7, len 37, two packets.
  - Required response: 12 words each; header 0x002D0007; seq 1 then 2; final word has byte 36 in [31:24], rest 0.
- Backpressure:
  - Stimulus: toggle dataOut_ready 1,0,0,1 during DATA.
  - Required response: dataOut/dataOut_last stable while stalled; no word duplicated or skipped, checked against a reference model.
- Stream aliasing and wrap:
  - Stimulus 1: streams 5 and 37 alternating.
  - Required response 1: seqs 1, 2, 3.
  - Stimulus 2: preload counter[0] to 0xFFFFFFFF via 2^32-1 packets, or force in simulation.
  - Required response 2: next header seq = 0x00000000.
- Illegal length:
  - Stimulus: len 0, then len 38.
  - Required response: lenError pulses once each, no dataOut_val, counters unchanged; the next legal packet carries seq 1.
- Reset mid-packet:
  - Stimulus: assert reset during HDR1.
  - Required response: dataOut_val=0 the next cycle; the following stream-3 packet carries seq 1.
